pe_layer_arbiter: RTL

- Per-pixel priority stage of the GBA PPU priority-evaluation path.
- Consumes one pixel per handshake from each of four BG layers, the OBJ layer and the backdrop.
- Selects the top-most visible layer and the second (blend-target) layer using GBA priority rules.
- Hands both to the downstream colour-special-effects stage.
- Two-stage pipeline with valid/ready flow control and a per-scanline pixel counter.

---
 rtl/pe_layer_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pe_layer_arbiter.sv
// GBA PPU per-pixel layer arbiter: picks the top-most visible layer and the
// blend-target layer from BG0-3, OBJ and backdrop over a two-stage pipeline.
module pe_layer_arbiter #(
  parameter int COLOR_W     = 15,
  parameter int LINE_PIXELS = 240
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 line_restart,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*COLOR_W-1:0] bg_color,
  input  logic [7:0]           bg_prio,
  input  logic [3:0]           bg_opaque,
  input  logic [3:0]           bg_enable,
  input  logic [COLOR_W-1:0]   obj_color,
  input  logic [1:0]           obj_prio,
  input  logic                 obj_opaque,
  input  logic                 obj_semi,
  input  logic                 obj_enable,
  input  logic [COLOR_W-1:0]   backdrop_color,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLOR_W-1:0]   top_color,
  output logic [2:0]           top_layer,
  output logic [COLOR_W-1:0]   second_color,
  output logic [2:0]           second_layer,
  output logic                 top_obj_semi,
  output logic [7:0]           pixel_x,
  output logic                 line_end
);

  // Candidate slot 0 is OBJ, slots 1..4 are BG0..BG3; the slot number doubles
  // as the rank field of the sort key.
  localparam int         NCAND          = 5;
  localparam logic [4:0] KEY_NONE       = 5'h1F;
  localparam logic [2:0] LAYER_OBJ      = 3'd4;
  localparam logic [2:0] LAYER_BACKDROP = 3'd5;
  localparam logic [7:0] LAST_X         = 8'(LINE_PIXELS - 1);

  logic advance;

  logic [4:0]         key_d      [NCAND];
  logic [COLOR_W-1:0] color_d    [NCAND];

  logic               s1_valid_q;
  logic [4:0]         s1_key_q   [NCAND];
  logic [COLOR_W-1:0] s1_color_q [NCAND];
  logic               s1_semi_q;
  logic [COLOR_W-1:0] s1_backdrop_q;

  logic [2:0]         top_idx, sec_idx;
  logic [4:0]         top_key, sec_key;
  logic [COLOR_W-1:0] top_color_d, second_color_d;
  logic [2:0]         top_layer_d, second_layer_d;
  logic               top_semi_d;

  logic               out_valid_q;
  logic [COLOR_W-1:0] top_color_q, second_color_q;
  logic [2:0]         top_layer_q, second_layer_q;
  logic               top_semi_q;
  logic [7:0]         pixel_x_q;

  function automatic logic [2:0] slot_to_layer(input logic [2:0] slot);
    return (slot == 3'd0) ? LAYER_OBJ : slot - 3'd1;
  endfunction

  // A held bubble still blocks the stage: both stages move together or not at all.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance & ~line_restart;

  always_comb begin
    key_d[0]   = (obj_enable & obj_opaque) ? {obj_prio, 3'd0} : KEY_NONE;
    color_d[0] = obj_color;
    for (int n = 0; n < 4; n++) begin
      key_d[n+1]   = (bg_enable[n] & bg_opaque[n]) ? {bg_prio[2*n +: 2], 3'(n + 1)} : KEY_NONE;
      color_d[n+1] = bg_color[n*COLOR_W +: COLOR_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      // NOTE: the pipeline data registers are few and small, so they are reset
      // too; this keeps post-reset outputs deterministic rather than X.
      s1_valid_q    <= 1'b0;
      s1_semi_q     <= 1'b0;
      s1_backdrop_q <= '0;
      for (int i = 0; i < NCAND; i++) begin
        s1_key_q[i]   <= KEY_NONE;
        s1_color_q[i] <= '0;
      end
    end else if (line_restart) begin
      s1_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q    <= in_valid & in_ready;
      s1_semi_q     <= obj_semi;
      s1_backdrop_q <= backdrop_color;
      for (int i = 0; i < NCAND; i++) begin
        s1_key_q[i]   <= key_d[i];
        s1_color_q[i] <= color_d[i];
      end
    end
  end

  // Keys are unique, so a strict less-than scan yields a single winner.
  always_comb begin
    // NOTE: every variable gets a default before the scans, so no path through
    // this block can leave a value unassigned and infer a latch.
    top_idx = 3'd0;
    top_key = s1_key_q[0];
    for (int i = 1; i < NCAND; i++) begin
      if (s1_key_q[i] < top_key) begin
        top_key = s1_key_q[i];
        top_idx = 3'(i);
      end
    end

    sec_idx = 3'd0;
    sec_key = KEY_NONE;
    for (int i = 0; i < NCAND; i++) begin
      if ((3'(i) != top_idx) && (s1_key_q[i] < sec_key)) begin
        sec_key = s1_key_q[i];
        sec_idx = 3'(i);
      end
    end

    if (top_key == KEY_NONE) begin
      top_layer_d = LAYER_BACKDROP;
      top_color_d = s1_backdrop_q;
    end else begin
      top_layer_d = slot_to_layer(top_idx);
      top_color_d = s1_color_q[top_idx];
    end

    // A backdrop top implies nothing else is visible, so second falls here too.
    if (sec_key == KEY_NONE) begin
      second_layer_d = LAYER_BACKDROP;
      second_color_d = s1_backdrop_q;
    end else begin
      second_layer_d = slot_to_layer(sec_idx);
      second_color_d = s1_color_q[sec_idx];
    end

    top_semi_d = (top_layer_d == LAYER_OBJ) & s1_semi_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid_q    <= 1'b0;
      top_color_q    <= '0;
      second_color_q <= '0;
      top_layer_q    <= LAYER_BACKDROP;
      second_layer_q <= LAYER_BACKDROP;
      top_semi_q     <= 1'b0;
    end else if (line_restart) begin
      out_valid_q <= 1'b0;
    end else if (advance) begin
      out_valid_q    <= s1_valid_q;
      top_color_q    <= top_color_d;
      second_color_q <= second_color_d;
      top_layer_q    <= top_layer_d;
      second_layer_q <= second_layer_d;
      top_semi_q     <= top_semi_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pixel_x_q <= '0;
    end else if (line_restart) begin
      pixel_x_q <= '0;
    end else if (out_valid_q & out_ready) begin
      pixel_x_q <= (pixel_x_q == LAST_X) ? 8'd0 : pixel_x_q + 8'd1;
    end
  end

  assign out_valid    = out_valid_q;
  assign top_color    = top_color_q;
  assign top_layer    = top_layer_q;
  assign second_color = second_color_q;
  assign second_layer = second_layer_q;
  assign top_obj_semi = top_semi_q;
  assign pixel_x      = pixel_x_q;
  assign line_end     = out_valid_q & (pixel_x_q == LAST_X);

endmodule
